sprite_motion_sched: RTL and testbench

//  Per-frame motion scheduler for NUM_SPRITES sprite offsets feeding LcdVga offset_x_in/offset_y_in.

---
 rtl/sprite_motion_sched.sv | 161 ++++++++++++++++
 tb/tb_sprite_motion_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_sched.sv
// Per-frame sprite offset scheduler: one shared adder sweeps X then Y of every sprite after each frame edge.
// Optional build macro SPRITE_WRAP_EN swaps edge bounce for wrap-around; default build bounces.
module sprite_motion_sched #(
    parameter int NUM_SPRITES = 4,
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_SIZE = 64,
    parameter int POS_W       = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    frame_int,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [3:0]              wr_idx,
    input  logic signed [POS_W-1:0] wr_x,
    input  logic signed [POS_W-1:0] wr_y,
    input  logic signed [POS_W-1:0] wr_dx,
    input  logic signed [POS_W-1:0] wr_dy,
    input  logic [3:0]              rd_idx,
    output logic signed [POS_W-1:0] rd_x,
    output logic signed [POS_W-1:0] rd_y,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    overrun
);
    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic signed [POS_W:0] MAX_X = (POS_W+1)'(SCREEN_W - SPRITE_SIZE);
    localparam logic signed [POS_W:0] MAX_Y = (POS_W+1)'(SCREEN_H - SPRITE_SIZE);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, DONE} state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        spr_idx, spr_idx_n;
    logic                    frame_prev, edge_pend;
    logic signed [POS_W-1:0] x_mem [NUM_SPRITES];
    logic signed [POS_W-1:0] y_mem [NUM_SPRITES];
    logic signed [POS_W-1:0] dx_mem[NUM_SPRITES];
    logic signed [POS_W-1:0] dy_mem[NUM_SPRITES];

    logic wr_ok, rd_ok, upd_en, axis_y;
    logic signed [POS_W-1:0] p, d, p_n, d_n;
    logic signed [POS_W:0]   s, max_v;

    assign wr_ok  = wr_en && ({1'b0, wr_idx} < 5'(NUM_SPRITES));
    assign rd_ok  = {1'b0, rd_idx} < 5'(NUM_SPRITES);
    assign axis_y = (state == UPD_Y);
    // A host write steals the register file for the cycle, so the sweep stalls.
    assign upd_en = (state == UPD_X || state == UPD_Y) && !wr_en;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            spr_idx <= '0;
        end else begin
            state   <= state_n;
            spr_idx <= spr_idx_n;
        end
    end

    always_comb begin
        state_n    = state;
        spr_idx_n  = spr_idx;
        busy       = (state != IDLE);
        sweep_done = (state == DONE);
        case (state)
            IDLE:  if (!wr_en && edge_pend && enable) begin
                       state_n   = UPD_X;
                       spr_idx_n = '0;
                   end
            UPD_X: if (!wr_en) state_n = UPD_Y;
            UPD_Y: if (!wr_en) begin
                       if (spr_idx == IDX_W'(NUM_SPRITES - 1)) begin
                           state_n = DONE;
                       end else begin
                           state_n   = UPD_X;
                           spr_idx_n = spr_idx + 1'b1;
                       end
                   end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            frame_prev <= 1'b0;
            edge_pend  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_prev <= frame_int;
            if (frame_int && !frame_prev) begin
                edge_pend <= 1'b1;
            end else if (edge_pend && (state != IDLE || !wr_en)) begin
                edge_pend <= 1'b0;
            end
            if (edge_pend && state != IDLE) overrun <= 1'b1;
        end
    end

    // Shared axis adder; the sum carries one extra bit so it cannot overflow.
    always_comb begin
        p     = axis_y ? y_mem[spr_idx]  : x_mem[spr_idx];
        d     = axis_y ? dy_mem[spr_idx] : dx_mem[spr_idx];
        max_v = axis_y ? MAX_Y : MAX_X;
        s     = {p[POS_W-1], p} + {d[POS_W-1], d};
        p_n   = s[POS_W-1:0];
        d_n   = d;
`ifdef SPRITE_WRAP_EN
        if (s[POS_W]) begin
            p_n = POS_W'(s + max_v + 1'b1);
        end else if (s > max_v) begin
            p_n = POS_W'(s - max_v - 1'b1);
        end
`else
        if (s[POS_W]) begin
            p_n = '0;
            d_n = d[POS_W-1] ? -d : d;
        end else if (s > max_v) begin
            p_n = max_v[POS_W-1:0];
            d_n = d[POS_W-1] ? d : -d;
        end
`endif
    end

    // NOTE: the sprite register file is reset because its reset contents (staggered
    // positions, unit velocity) are architectural state, not don't-care storage.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_mem[i]  <= POS_W'(i * SPRITE_SIZE);
                y_mem[i]  <= '0;
                dx_mem[i] <= POS_W'(1);
                dy_mem[i] <= POS_W'(1);
            end
        end else if (wr_ok) begin
            x_mem[wr_idx[IDX_W-1:0]]  <= wr_x;
            y_mem[wr_idx[IDX_W-1:0]]  <= wr_y;
            dx_mem[wr_idx[IDX_W-1:0]] <= wr_dx;
            dy_mem[wr_idx[IDX_W-1:0]] <= wr_dy;
        end else if (upd_en) begin
            if (axis_y) begin
                y_mem[spr_idx]  <= p_n;
                dy_mem[spr_idx] <= d_n;
            end else begin
                x_mem[spr_idx]  <= p_n;
                dx_mem[spr_idx] <= d_n;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_x <= '0;
            rd_y <= '0;
        end else begin
            rd_x <= rd_ok ? x_mem[rd_idx[IDX_W-1:0]] : '0;
            rd_y <= rd_ok ? y_mem[rd_idx[IDX_W-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_sprite_motion_sched.sv
// Directed self-checking bench for sprite_motion_sched (4 sprites, 800x480, 64 px sprites).
// Expected values follow the bounce rules, or the wrap rules when SPRITE_WRAP_EN is defined.
module tb_sprite_motion_sched;
`ifdef SPRITE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic               clk_sys = 1'b0;
    logic               reset = 1'b1, frame_int = 1'b0, enable = 1'b1, wr_en = 1'b0;
    logic [3:0]         wr_idx = '0, rd_idx = '0;
    logic signed [15:0] wr_x = '0, wr_y = '0, wr_dx = '0, wr_dy = '0;
    logic signed [15:0] rd_x, rd_y;
    logic               busy, sweep_done, overrun;

    int checks = 0;
    int failures = 0;
    int lat, dones;
    bit seen_busy;

    sprite_motion_sched dut (
        .clk_sys(clk_sys), .reset(reset), .frame_int(frame_int), .enable(enable),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_dx(wr_dx), .wr_dy(wr_dy),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
        .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input int idx, input int ex, input int ey);
        rd_idx = 4'(idx);
        tick();
        check({tag, ".x"}, rd_x, ex);
        check({tag, ".y"}, rd_y, ey);
    endtask

    task automatic write(input int idx, input int x, input int y, input int dx, input int dy);
        wr_idx = 4'(idx); wr_x = 16'(x); wr_y = 16'(y); wr_dx = 16'(dx); wr_dy = 16'(dy);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    // Pulses frame_int and counts cycles (edge-sampling cycle = 1) until sweep_done.
    task automatic frame(output int n);
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
        n = 1;
        while (!sweep_done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst.busy", busy, 0);
        check("rst.overrun", overrun, 0);
        check("rst.done", sweep_done, 0);
        read_check("rst.spr2", 2, 128, 0);
        read_check("rst.spr5", 5, 0, 0);

        // One frame: latency 2*4+2, busy through DONE, sprite 0 moves to (1,1)
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
        tick();
        check("f1.busy_early", busy, 1);
        lat = 2;
        while (!sweep_done && lat < 200) begin
            tick();
            lat++;
        end
        check("f1.latency", lat, 10);
        check("f1.busy_done", busy, 1);
        tick();
        check("f1.busy_after", busy, 0);
        check("f1.done_pulse", sweep_done, 0);
        read_check("f1.spr0", 0, 1, 1);
        read_check("f1.spr3", 3, 193, 1);

        // Right/top edge and negative velocity on idx0 (MAX_X=736, MAX_Y=416)
        write(0, 735, 415, 3, -5);
        frame(lat);
        check("f2.latency", lat, 10);
        read_check("f2.spr0", 0, WRAP ? 1 : 736, 410);
        frame(lat);
        read_check("f3.spr0", 0, WRAP ? 4 : 733, 405);
        write(0, 2, 100, -4, 0);
        frame(lat);
        read_check("f4.spr0", 0, WRAP ? 735 : 0, 100);
        frame(lat);
        read_check("f5.spr0", 0, WRAP ? 731 : 4, 100);

        // Out-of-range write ignored; sprite 3 has had 5 frames
        write(7, 1, 2, 3, 4);
        read_check("oor.spr3", 3, 197, 5);
        read_check("oor.spr7", 7, 0, 0);

        // Y underflow and x landing exactly on MAX (in range, velocity kept)
        write(1, 10, 3, 0, -5);
        write(2, 733, 0, 3, 0);
        frame(lat);
        read_check("f6.spr1", 1, 10, WRAP ? 415 : 0);
        read_check("f6.spr2", 2, 736, 0);
        frame(lat);
        read_check("f7.spr1", 1, 10, WRAP ? 410 : 5);
        read_check("f7.spr2", 2, WRAP ? 2 : 736, 0);
        write(2, 1, 0, -3, 0);
        frame(lat);
        read_check("f8.spr2", 2, WRAP ? 735 : 0, 0);
        frame(lat);
        read_check("f9.spr2", 2, WRAP ? 732 : 3, 0);
        check("pre_ovr.overrun", overrun, 0);

        // Second edge 3 cycles into a sweep: overrun, single sweep
        write(0, 100, 100, 2, 2);
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
        dones = 0;
        tick(); tick(); tick();
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (sweep_done) dones++;
        end
        check("ovr.flag", overrun, 1);
        check("ovr.dones", dones, 1);
        read_check("ovr.spr0", 0, 102, 102);

        // Host writes on idx3 held 3 cycles during a sweep: stall by 3, idx3 swept once
        write(3, 50, 60, 1, 1);
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
        wr_idx = 4'd3; wr_x = 16'sd10; wr_y = 16'sd20; wr_dx = 16'sd1; wr_dy = 16'sd1;
        wr_en = 1'b1;
        tick(); tick(); tick();
        wr_en = 1'b0;
        lat = 4;
        while (!sweep_done && lat < 200) begin
            tick();
            lat++;
        end
        check("stall.latency", lat, 13);
        tick();
        check("stall.done_pulse", sweep_done, 0);
        read_check("stall.spr3", 3, 11, 21);
        check("stall.overrun_sticky", overrun, 1);

        // Reset mid-sweep discards the partial frame and clears overrun
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst.busy", busy, 0);
        check("midrst.overrun", overrun, 0);
        read_check("midrst.spr0", 0, 0, 0);
        read_check("midrst.spr3", 3, 192, 0);

        // enable low: frame edge ignored
        enable = 1'b0;
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy) seen_busy = 1'b1;
        end
        check("dis.busy", seen_busy, 0);
        read_check("dis.spr2", 2, 128, 0);
        enable = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
